// File: rtl/keypad_scanner.sv
// 4-row x 5-column key matrix scanner with a row synchroniser and debounce.
// Turns asynchronous, bouncing row inputs into a single-cycle newkey pulse
// with a registered keycode (col*4 + row) and a key_held level.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] rows_n,
    output logic [4:0] cols_n,
    output logic       newkey,
    output logic [4:0] keycode,
    output logic       key_held
);

    localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD
    } state_t;

    state_t           r_state, w_state_next;
    logic [3:0]       r_rs_meta, r_rs;
    logic [2:0]       r_col, w_col_next;
    logic [DIV_W-1:0] r_div, w_div_next;
    logic [DB_W-1:0]  r_cnt, w_cnt_next;
    logic [1:0]       r_row, w_row_next;
    logic             r_newkey, w_newkey_next;
    logic [4:0]       r_keycode, w_keycode_next;
    logic             r_key_held, w_key_held_next;

    logic [2:0]       w_col_adv;
    logic [1:0]       w_low_row;
    logic             w_rs_idle;
    logic             w_rs_sel;

    assign w_col_adv = (r_col == 3'd4) ? 3'd0 : r_col + 3'd1;
    assign w_rs_idle = &r_rs;
    assign w_rs_sel  = r_rs[r_row];

    // Lowest-indexed low row wins when several rows in a column are pressed.
    always_comb begin
        w_low_row = 2'd3;
        if (!r_rs[0])      w_low_row = 2'd0;
        else if (!r_rs[1]) w_low_row = 2'd1;
        else if (!r_rs[2]) w_low_row = 2'd2;
    end

    // Two-flop synchroniser for the asynchronous row inputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rs_meta <= '1;
            r_rs      <= '1;
        end else begin
            r_rs_meta <= rows_n;
            r_rs      <= r_rs_meta;
        end
    end

    // Next-state and output decode for the scan / debounce / hold sequence.
    always_comb begin
        w_state_next    = r_state;
        w_col_next      = r_col;
        w_div_next      = r_div;
        w_cnt_next      = r_cnt;
        w_row_next      = r_row;
        w_newkey_next   = 1'b0;
        w_keycode_next  = r_keycode;
        w_key_held_next = r_key_held;
        case (r_state)
            ST_SCAN: begin
                if (r_div == DIV_LAST) begin
                    w_div_next = '0;
                    if (w_rs_idle) begin
                        w_col_next = w_col_adv;
                    end else begin
                        w_row_next   = w_low_row;
                        w_cnt_next   = '0;
                        w_state_next = ST_DEBOUNCE;
                    end
                end else begin
                    w_div_next = r_div + 1'b1;
                end
            end
            ST_DEBOUNCE: begin
                if (!w_rs_sel) begin
                    if (r_cnt == DB_LAST) begin
                        w_newkey_next   = 1'b1;
                        w_keycode_next  = {r_col, r_row};
                        w_key_held_next = 1'b1;
                        w_cnt_next      = '0;
                        w_state_next    = ST_HELD;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end else begin
                    w_col_next   = w_col_adv;
                    w_div_next   = '0;
                    w_state_next = ST_SCAN;
                end
            end
            ST_HELD: begin
                if (w_rs_idle) begin
                    if (r_cnt == DB_LAST) begin
                        w_key_held_next = 1'b0;
                        w_cnt_next      = '0;
                        w_col_next      = w_col_adv;
                        w_div_next      = '0;
                        w_state_next    = ST_SCAN;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end else begin
                    w_cnt_next = '0;
                end
            end
            default: begin
                w_state_next = ST_SCAN;
            end
        endcase
    end

    // State and datapath registers; reset aborts any debounce or hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_SCAN;
            r_col      <= '0;
            r_div      <= '0;
            r_cnt      <= '0;
            r_row      <= '0;
            r_newkey   <= 1'b0;
            r_keycode  <= '0;
            r_key_held <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_col      <= w_col_next;
            r_div      <= w_div_next;
            r_cnt      <= w_cnt_next;
            r_row      <= w_row_next;
            r_newkey   <= w_newkey_next;
            r_keycode  <= w_keycode_next;
            r_key_held <= w_key_held_next;
        end
    end

    assign cols_n   = ~(5'b00001 << r_col);
    assign newkey   = r_newkey;
    assign keycode  = r_keycode;
    assign key_held = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a behavioural key matrix pulls rows low only while
// the pressed key's column is driven; expected keycodes are queued on press and
// checked when newkey fires.
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV        = 4;
    localparam int unsigned DEBOUNCE_CYCLES = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rows_n;
    logic [4:0] cols_n;
    logic       newkey;
    logic [4:0] keycode;
    logic       key_held;

    logic [19:0] pressed = '0;
    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned nk_count = 0;
    int unsigned exp_q[$];
    logic        mon_en = 1'b0;
    logic        rst_at_edge = 1'b1;
    logic        prev_nk = 1'b0;
    logic [4:0]  prev_kc = '0;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .rows_n  (rows_n),
        .cols_n  (cols_n),
        .newkey  (newkey),
        .keycode (keycode),
        .key_held(key_held)
    );

    always #5 clock = ~clock;

    // Key matrix: a pressed key shorts its row to its column drive.
    always_comb begin
        rows_n = '1;
        for (int c = 0; c < 5; c++)
            for (int r = 0; r < 4; r++)
                if (pressed[c*4+r] && (cols_n[c] === 1'b0)) rows_n[r] = 1'b0;
    end

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clock) rst_at_edge <= reset;

    // Scoreboard consumer and per-cycle invariants.
    always @(negedge clock) begin
        if (mon_en) begin
            chk("cols_onehot", $countones(~cols_n), 1);
            if (newkey) begin
                chk("nk_single", prev_nk, 0);
                chk("held_with_nk", key_held, 1);
                chk("sb_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("keycode", keycode, exp_q.pop_front());
                nk_count++;
            end else if (!rst_at_edge) begin
                chk("kc_stable", keycode, prev_kc);
            end
        end
        prev_nk = newkey;
        prev_kc = keycode;
    end

    task automatic wait_newkey(input int unsigned max);
        for (int unsigned i = 0; i < max; i++) begin
            @(negedge clock);
            if (newkey) break;
        end
        chk("nk_wait", newkey, 1);
    endtask

    task automatic wait_held_low(input int unsigned max, output int unsigned n);
        n = 0;
        for (int unsigned i = 0; i < max; i++) begin
            @(negedge clock);
            n++;
            if (!key_held) break;
        end
        chk("held_fall", key_held, 0);
    endtask

    // Returns at the first negedge on which column c is driven.
    task automatic wait_col_start(input int unsigned c);
        logic [4:0] tgt;
        logic [4:0] prev;
        tgt  = ~(5'b00001 << c);
        prev = cols_n;
        for (int unsigned i = 0; i < 100; i++) begin
            @(negedge clock);
            if (cols_n == tgt && prev != tgt) break;
            prev = cols_n;
        end
        chk("col_start", cols_n, tgt);
    endtask

    initial begin
        int unsigned n;
        int unsigned nk0;
        logic [4:0] kc0;

        // 1. Reset values and free-running column scan.
        repeat (3) @(negedge clock);
        mon_en = 1'b1;
        chk("rst_cols", cols_n, 5'b11110);
        chk("rst_newkey", newkey, 0);
        chk("rst_keycode", keycode, 0);
        chk("rst_held", key_held, 0);
        reset = 1'b0;
        for (int unsigned k = 0; k < 25; k++) begin
            chk("scan_seq", cols_n, 5'(~(5'b00001 << ((k / SCAN_DIV) % 5))));
            @(negedge clock);
        end

        // 2. Col 2 row 1, long hold, release timing and scan resume.
        nk0 = nk_count;
        exp_q.push_back(9);
        pressed[9] = 1'b1;
        wait_newkey(200);
        repeat (40) @(negedge clock);
        pressed = '0;
        wait_held_low(60, n);
        chk("release_lat", n, DEBOUNCE_CYCLES + 2);
        chk("resume_col3", cols_n, 5'b10111);
        chk("one_pulse", nk_count - nk0, 1);

        // 3. Bounce on col 4 row 0 for 5 cycles.
        kc0 = keycode;
        nk0 = nk_count;
        wait_col_start(4);
        pressed[16] = 1'b1;
        repeat (5) @(negedge clock);
        pressed = '0;
        repeat (2) @(negedge clock);
        chk("deb_col_kept", cols_n, 5'b01111);
        @(negedge clock);
        chk("bounce_col0", cols_n, 5'b11110);
        repeat (4) @(negedge clock);
        chk("div_restart", cols_n, 5'b11101);
        chk("bounce_kc", keycode, kc0);
        chk("bounce_no_nk", nk_count - nk0, 0);

        // 4. Second key while held is ignored; then pressed alone.
        nk0 = nk_count;
        exp_q.push_back(3);
        pressed[3] = 1'b1;
        wait_newkey(200);
        pressed[4] = 1'b1;
        repeat (30) @(negedge clock);
        chk("held_extra", key_held, 1);
        pressed = '0;
        wait_held_low(60, n);
        chk("held_ignore", nk_count - nk0, 1);
        exp_q.push_back(4);
        pressed[4] = 1'b1;
        wait_newkey(200);
        pressed = '0;
        wait_held_low(60, n);

        // 5. Two rows in col 3: lowest row wins.
        exp_q.push_back(13);
        pressed[13] = 1'b1;
        pressed[15] = 1'b1;
        wait_newkey(200);
        pressed = '0;
        wait_held_low(60, n);

        // 6. Reset in the 5th debounce cycle, then recovery with key held.
        nk0 = nk_count;
        wait_col_start(2);
        pressed[10] = 1'b1;
        repeat (8) @(negedge clock);
        chk("in_debounce", cols_n, 5'b11011);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_cols", cols_n, 5'b11110);
        chk("mid_rst_nk", newkey, 0);
        chk("mid_rst_kc", keycode, 0);
        chk("mid_rst_held", key_held, 0);
        @(negedge clock);
        reset = 1'b0;
        chk("rst_no_nk", nk_count - nk0, 0);
        exp_q.push_back(10);
        wait_newkey(200);
        pressed = '0;
        wait_held_low(60, n);

        chk("sb_drained", exp_q.size(), 0);
        chk("total_nk", nk_count, 5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream stage of the calculator. Scans a 4-row x 5-column key matrix and synchronises and debounces the row inputs.
- Produces the one-cycle newkey pulse and the 5-bit keycode that the calculator top level and keypad interpreter consume.
- Contains the only asynchronous inputs in the calculator datapath. Everything downstream sees clean single-cycle events.

Parameters:
- SCAN_DIV, 1000: clock cycles each column stays driven during scanning (minimum 2).
- DEBOUNCE_CYCLES, 20: consecutive stable cycles required to accept a press or a release (minimum 2).

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rows_n  input  4  matrix rows, active-low, pulled up externally, asynchronous to clock
- cols_n  output  5  column drives, active-low, exactly one bit low at all times
- newkey  output  1  high for exactly one cycle per accepted keypress
- keycode  output  5  code of the accepted key = col*4 + row (range 0..19); valid with newkey and held until the next newkey
- key_held  output  1  high from the newkey cycle until the release is debounced

Behaviour:
- Reset (synchronous, active-high, takes priority over everything):
  - cols_n=5'b11110, newkey=0, keycode=0, key_held=0.
  - State SCAN, column index 0, divider and debounce counters 0, both synchroniser stages all-ones.
  - Reset in any state, including mid-debounce or mid-hold, aborts with no newkey.
- Synchroniser: rows_n passes through a 2-flop synchroniser (rs). All decisions use rs, so 2 cycles of input latency.
- States are SCAN, DEBOUNCE, HELD.
- SCAN:
  - The divider counts 0..SCAN_DIV-1 with the current column driven.
  - At count SCAN_DIV-1, rs is sampled.
  - If all rs bits are high: the column index advances (4 wraps to 0), cols_n updates on the next cycle, and the divider returns to 0.
  - If any rs bit is low: latch row r = lowest-indexed low bit, keep the column, clear the debounce counter, go to DEBOUNCE.
- DEBOUNCE:
  - The column stays driven.
  - Each cycle with rs[r]=0, the counter increments.
  - When rs[r]=0 and the counter equals DEBOUNCE_CYCLES-1: on the next cycle newkey=1, keycode=col*4+r, key_held=1, state goes to HELD.
  - Any cycle with rs[r]=1 returns to SCAN with no newkey. The column advances to the next one and the divider restarts at 0.
  - Other rows going low during DEBOUNCE are ignored.
- HELD:
  - newkey falls after one cycle. The column stays driven.
  - The counter counts consecutive cycles with rs all-ones; any low bit clears it.
  - When the count reaches DEBOUNCE_CYCLES-1 with rs all-ones: next cycle key_held=0, state goes to SCAN, the column advances, and the divider restarts.
  - Additional keys pressed while held are ignored. No auto-repeat: one newkey per press, however long it is held.
- Simultaneous keys:
  - Same column: the lowest row wins.
  - Different columns: the first column scanned wins.
- keycode only changes on a newkey cycle. newkey is never high on two consecutive cycles.
- cols_n has exactly one zero bit in every cycle, including the cycles during and after reset.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8):
1. Reset -> cols_n=11110, newkey=0, keycode=0, key_held=0. With no key pressed, cols_n cycles 11110 -> 11101 -> 11011 -> 10111 -> 01111 -> 11110, 4 cycles per column.
2. Press col 2 row 1 (rows_n=1101 while cols_n=11011) held 40 cycles, then released -> exactly one newkey pulse with keycode=9. key_held falls 8 cycles (+2 sync) after release, then scanning resumes at col 3.
3. Bounce: rows_n low on row 0 at col 4 for 5 cycles, then high -> no newkey, scanning resumes at col 0, keycode unchanged.
4. Hold col 0 row 3 (keycode 3), then press col 1 row 0 while it is still held, release both -> single newkey with keycode=3. After the release debounce, pressing col 1 row 0 alone -> newkey with keycode=4.
5. rows_n=0101 at col 3 (rows 1 and 3 low) -> keycode=13 (row 1 wins).
6. Assert reset in the 5th debounce cycle -> no newkey, outputs at reset values. Release reset with the key still pressed -> a normal newkey follows once the scan reaches that column.
